// File: rtl/return_address_stack.sv
// -----------------------------------------------------------------------------
// return_address_stack
//
// Return-address predictor for a MIPS-style pipeline. A jal in decode pushes
// its return address; a jr $ra in decode pops the top entry, which becomes the
// predicted target. When the jr resolves in execute, the real target is
// compared with the outstanding prediction and hit/miss statistics are kept.
//
// The stack is a circular buffer: pushing onto a full stack silently
// overwrites the oldest entry, so deep call chains lose their outermost
// frames rather than stalling.
//
// Ports
//   Clk            in   sole clock, rising edge
//   Reset          in   asynchronous, active-low reset
//   Push           in   jal in decode: push PushAddress
//   PushAddress    in   32-bit return address (PC + 4)
//   Pop            in   jr $ra in decode: pop top entry as prediction
//   Flush          in   pipeline flush: empty stack, drop pending prediction
//   ResolveValid   in   jr resolved in execute this cycle
//   ResolveAddress in   32-bit actual jr target
//   TopAddress     out  current top entry (combinational), 0 when empty
//   TopValid       out  stack non-empty (combinational)
//   Underflow      out  registered 1-cycle pulse: Pop on an empty stack
//   Mispredict     out  registered 1-cycle pulse: resolved target != prediction
//   HitCount       out  saturating count of correct predictions
//   MissCount      out  saturating count of wrong predictions
//
// Protocol: there is no back-pressure. Push, Pop, Flush and ResolveValid are
// single-cycle qualifiers sampled on every rising edge; each asserted cycle is
// one event. At most one prediction is outstanding: a Pop arms it, the next
// ResolveValid consumes it, and a ResolveValid with nothing armed is ignored.
// Priority within a cycle is Flush > Push&Pop > Push > Pop; resolution of the
// old prediction happens before a same-cycle Pop re-arms a new one.
// -----------------------------------------------------------------------------
module return_address_stack #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Push,
  input  logic [31:0]     PushAddress,
  input  logic            Pop,
  input  logic            Flush,
  input  logic            ResolveValid,
  input  logic [31:0]     ResolveAddress,
  output logic [31:0]     TopAddress,
  output logic            TopValid,
  output logic            Underflow,
  output logic            Mispredict,
  output logic [CNTW-1:0] HitCount,
  output logic [CNTW-1:0] MissCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [31:0]     entry_q [DEPTH];
  logic [31:0]     entry_d [DEPTH];
  logic [AW-1:0]   tos_q, tos_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pend_valid_q, pend_valid_d;
  logic [31:0]     pend_addr_q, pend_addr_d;
  logic            underflow_q, underflow_d;
  logic            mispredict_q, mispredict_d;
  logic [CNTW-1:0] hit_q, hit_d;
  logic [CNTW-1:0] miss_q, miss_d;

  logic            empty;
  logic            full;
  logic [AW-1:0]   tos_inc;
  logic [AW-1:0]   tos_dec;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign tos_inc = tos_q + AW'(1);
  assign tos_dec = tos_q - AW'(1);

  always_comb begin
    entry_d      = entry_q;
    tos_d        = tos_q;
    count_d      = count_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    underflow_d  = 1'b0;
    mispredict_d = 1'b0;
    hit_d        = hit_q;
    miss_d       = miss_q;

    if (Flush) begin
      // Entries are left as-is; an empty count makes them invisible.
      count_d      = '0;
      tos_d        = '0;
      pend_valid_d = 1'b0;
    end else begin
      // Resolve the outstanding prediction first so a Pop in the same cycle
      // can re-arm it below.
      if (ResolveValid && pend_valid_q) begin
        pend_valid_d = 1'b0;
        if (ResolveAddress == pend_addr_q) begin
          if (hit_q != '1) hit_d = hit_q + CNTW'(1);
        end else begin
          mispredict_d = 1'b1;
          if (miss_q != '1) miss_d = miss_q + CNTW'(1);
        end
      end

      if (Push && Pop && !empty) begin
        // jal immediately after jr: replace the top in place.
        pend_addr_d      = entry_q[tos_q];
        pend_valid_d     = 1'b1;
        entry_d[tos_q]   = PushAddress;
      end else if (Push) begin
        // Also covers Push&Pop on an empty stack, which still flags underflow.
        tos_d            = tos_inc;
        entry_d[tos_inc] = PushAddress;
        if (!full) count_d = count_q + CW'(1);
        if (Pop) begin
          underflow_d  = 1'b1;
          pend_valid_d = 1'b0;
        end
      end else if (Pop) begin
        if (!empty) begin
          pend_addr_d  = entry_q[tos_q];
          pend_valid_d = 1'b1;
          tos_d        = tos_dec;
          count_d      = count_q - CW'(1);
        end else begin
          underflow_d  = 1'b1;
          pend_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      tos_q        <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      underflow_q  <= 1'b0;
      mispredict_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      entry_q      <= entry_d;
      tos_q        <= tos_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      underflow_q  <= underflow_d;
      mispredict_q <= mispredict_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  // No bypass: a push becomes visible on the top only after its edge.
  assign TopValid   = !empty;
  assign TopAddress = empty ? 32'h0 : entry_q[tos_q];
  assign Underflow  = underflow_q;
  assign Mispredict = mispredict_q;
  assign HitCount   = hit_q;
  assign MissCount  = miss_q;

endmodule

// File: tb/tb_return_address_stack.sv
// -----------------------------------------------------------------------------
// tb_return_address_stack
//
// Directed bench for return_address_stack. Two instances share all inputs:
// u_dut (DEPTH=8, CNTW=16) carries the main scenarios, u_sat (CNTW=2) shows
// counter saturation. Inputs change 1 ns after a rising edge and outputs are
// sampled there too, so every sample sees the settled post-edge state.
// -----------------------------------------------------------------------------
module tb_return_address_stack;

  logic        Clk;
  logic        Reset;
  logic        Push;
  logic [31:0] PushAddress;
  logic        Pop;
  logic        Flush;
  logic        ResolveValid;
  logic [31:0] ResolveAddress;

  logic [31:0] top_address;
  logic        top_valid;
  logic        underflow;
  logic        mispredict;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic [31:0] sat_top_address;
  logic        sat_top_valid;
  logic        sat_underflow;
  logic        sat_mispredict;
  logic [1:0]  sat_hit_count;
  logic [1:0]  sat_miss_count;

  int n_cmp = 0;
  int n_err = 0;

  return_address_stack #(.DEPTH(8), .CNTW(16)) u_dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Push           (Push),
    .PushAddress    (PushAddress),
    .Pop            (Pop),
    .Flush          (Flush),
    .ResolveValid   (ResolveValid),
    .ResolveAddress (ResolveAddress),
    .TopAddress     (top_address),
    .TopValid       (top_valid),
    .Underflow      (underflow),
    .Mispredict     (mispredict),
    .HitCount       (hit_count),
    .MissCount      (miss_count)
  );

  return_address_stack #(.DEPTH(8), .CNTW(2)) u_sat (
    .Clk            (Clk),
    .Reset          (Reset),
    .Push           (Push),
    .PushAddress    (PushAddress),
    .Pop            (Pop),
    .Flush          (Flush),
    .ResolveValid   (ResolveValid),
    .ResolveAddress (ResolveAddress),
    .TopAddress     (sat_top_address),
    .TopValid       (sat_top_valid),
    .Underflow      (sat_underflow),
    .Mispredict     (sat_mispredict),
    .HitCount       (sat_hit_count),
    .MissCount      (sat_miss_count)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // One cycle with the given qualifiers; returns 1 ns after the edge.
  task automatic cycle(input logic push, input logic [31:0] paddr,
                       input logic pop, input logic flush,
                       input logic rv, input logic [31:0] raddr);
    Push           = push;
    PushAddress    = paddr;
    Pop            = pop;
    Flush          = flush;
    ResolveValid   = rv;
    ResolveAddress = raddr;
    @(posedge Clk);
    #1;
    Push           = 1'b0;
    PushAddress    = '0;
    Pop            = 1'b0;
    Flush          = 1'b0;
    ResolveValid   = 1'b0;
    ResolveAddress = '0;
  endtask

  task automatic do_push(input logic [31:0] a);
    cycle(1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_pop();
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_resolve(input logic [31:0] a);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic do_idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_top"},        top_address,     32'h0);
    check_eq({tag, "_valid"},      top_valid,       32'h0);
    check_eq({tag, "_underflow"},  underflow,       32'h0);
    check_eq({tag, "_mispredict"}, mispredict,      32'h0);
    check_eq({tag, "_hit"},        hit_count,       32'h0);
    check_eq({tag, "_miss"},       miss_count,      32'h0);
    check_eq({tag, "_sat_mis"},    sat_mispredict,  32'h0);
    check_eq({tag, "_sat_hit"},    sat_hit_count,   32'h0);
    check_eq({tag, "_sat_miss"},   sat_miss_count,  32'h0);
  endtask

  // Asserts reset between edges, checks outputs before any clock edge, shows
  // that a push during reset is discarded, then releases on a falling edge.
  task automatic reset_pulse(input string tag);
    Reset = 1'b0;
    #2;
    check_all_zero(tag);
    Push        = 1'b1;
    PushAddress = 32'hDEAD;
    Pop         = 1'b1;
    @(posedge Clk);
    #1;
    check_eq({tag, "_held_top"}, top_address, 32'h0);
    check_eq({tag, "_held_uf"},  underflow,   32'h0);
    Push        = 1'b0;
    PushAddress = '0;
    Pop         = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    Reset          = 1'b0;
    Push           = 1'b0;
    PushAddress    = '0;
    Pop            = 1'b0;
    Flush          = 1'b0;
    ResolveValid   = 1'b0;
    ResolveAddress = '0;

    #7;
    check_all_zero("rst");
    @(negedge Clk);
    Reset = 1'b1;

    // Basic LIFO order.
    do_push(32'h100);
    do_push(32'h200);
    do_push(32'h300);
    check_eq("lifo_top3",   top_address, 32'h300);
    check_eq("lifo_valid3", top_valid,   32'h1);
    do_pop();
    check_eq("lifo_pop1", top_address, 32'h200);
    do_pop();
    check_eq("lifo_pop2", top_address, 32'h100);
    do_pop();
    check_eq("lifo_pop3_top",   top_address, 32'h0);
    check_eq("lifo_pop3_valid", top_valid,   32'h0);
    check_eq("lifo_no_uf",      underflow,   32'h0);

    // Overflow wrap: nine pushes into eight entries lose 0x4.
    for (int k = 1; k <= 9; k++) do_push(32'(4 * k));
    check_eq("wrap_top", top_address, 32'h24);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("wrap_pop%0d", i), top_address, 32'(32'h24 - 4 * i));
      do_pop();
    end
    check_eq("wrap_empty_valid", top_valid, 32'h0);
    check_eq("wrap_empty_uf",    underflow, 32'h0);
    do_pop();
    check_eq("uf_pulse",       underflow, 32'h1);
    check_eq("uf_valid",       top_valid, 32'h0);
    do_idle();
    check_eq("uf_pulse_end",   underflow, 32'h0);
    check_eq("uf_hit",         hit_count, 32'h0);
    check_eq("uf_miss",        miss_count, 32'h0);

    // Push and pop together replace the top; prediction is the old top.
    do_push(32'h400);
    check_eq("pp_before", top_address, 32'h400);
    cycle(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("pp_top",   top_address, 32'h500);
    check_eq("pp_valid", top_valid,   32'h1);
    check_eq("pp_uf",    underflow,   32'h0);
    do_resolve(32'h400);
    check_eq("pp_hit",  hit_count,  32'h1);
    check_eq("pp_mis",  mispredict, 32'h0);
    check_eq("pp_miss", miss_count, 32'h0);
    do_pop();
    check_eq("pp_count_one", top_valid, 32'h0);

    reset_pulse("rst2");

    // Mispredict.
    do_push(32'h40);
    do_pop();
    do_resolve(32'h44);
    check_eq("mp_pulse", mispredict, 32'h1);
    check_eq("mp_miss",  miss_count, 32'h1);
    check_eq("mp_hit",   hit_count,  32'h0);
    do_idle();
    check_eq("mp_pulse_end", mispredict, 32'h0);
    // Nothing pending any more: resolve is ignored.
    do_resolve(32'h40);
    check_eq("nopend_hit",  hit_count,  32'h0);
    check_eq("nopend_miss", miss_count, 32'h1);
    check_eq("nopend_mis",  mispredict, 32'h0);

    // Flush wins over a same-cycle resolve and drops the prediction.
    do_push(32'h10);
    do_push(32'h20);
    do_pop();
    check_eq("fl_before", top_address, 32'h10);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h20);
    check_eq("fl_valid", top_valid,   32'h0);
    check_eq("fl_top",   top_address, 32'h0);
    check_eq("fl_hit",   hit_count,   32'h0);
    check_eq("fl_miss",  miss_count,  32'h1);
    check_eq("fl_mis",   mispredict,  32'h0);
    do_resolve(32'h20);
    check_eq("fl_dropped_hit", hit_count, 32'h0);
    do_push(32'h30);
    check_eq("fl_push_top",   top_address, 32'h30);
    check_eq("fl_push_valid", top_valid,   32'h1);
    do_pop();

    // Push and pop on an empty stack: acts as push, flags underflow and
    // cancels the prediction armed by the pop above.
    cycle(1'b1, 32'h70, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("ppe_uf",    underflow,   32'h1);
    check_eq("ppe_top",   top_address, 32'h70);
    check_eq("ppe_valid", top_valid,   32'h1);
    do_resolve(32'h30);
    check_eq("ppe_nopend_hit", hit_count,  32'h0);
    check_eq("ppe_uf_end",     underflow,  32'h0);
    do_pop();

    // Resolve and pop in the same cycle: old prediction scored, new one armed.
    do_push(32'hA0);
    do_push(32'hB0);
    do_pop();
    check_eq("rearm_top", top_address, 32'hA0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hB0);
    check_eq("rearm_hit1",  hit_count, 32'h1);
    check_eq("rearm_empty", top_valid, 32'h0);
    do_resolve(32'hA0);
    check_eq("rearm_hit2", hit_count,  32'h2);
    check_eq("rearm_mis",  mispredict, 32'h0);
    check_eq("rearm_miss", miss_count, 32'h1);

    // Saturation with the 2-bit counter instance.
    reset_pulse("rst3");
    for (int i = 1; i <= 4; i++) begin
      do_push(32'h80);
      do_pop();
      do_resolve(32'h80);
      check_eq($sformatf("sat_hit%0d", i), sat_hit_count, 32'((i > 3) ? 3 : i));
      check_eq($sformatf("wide_hit%0d", i), hit_count, 32'(i));
    end
    do_push(32'h90);
    do_pop();
    do_resolve(32'h91);
    check_eq("sat_mis_pulse", sat_mispredict, 32'h1);
    check_eq("sat_miss",      sat_miss_count, 32'h1);
    check_eq("sat_hit_hold",  sat_hit_count,  32'h3);
    // Reset while the mispredict pulse is high clears everything at once.
    reset_pulse("rst_mid");
    do_push(32'hC0);
    check_eq("post_rst_top",   top_address, 32'hC0);
    check_eq("post_rst_valid", top_valid,   32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/return_address_stack.md
RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of stack entries (power of two, 2..32).
REQ-002 Parameter CNTW, default 16, width of the hit/miss statistics counters.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 Push  input  1  jal in decode; push a return address.
REQ-006 PushAddress  input  32  return address to push (PCResult + 4).
REQ-007 Pop  input  1  jr $ra in decode; pop top entry as predicted target.
REQ-008 Flush  input  1  pipeline flush; empties stack and drops pending prediction.
REQ-009 ResolveValid  input  1  jr resolved in execute this cycle.
REQ-010 ResolveAddress  input  32  actual jr target (register value).
REQ-011 TopAddress  output  32  combinational current top entry; 0 when empty.
REQ-012 TopValid  output  1  combinational, 1 when stack non-empty.
REQ-013 Underflow  output  1  registered 1-cycle pulse: Pop while empty.
REQ-014 Mispredict  output  1  registered 1-cycle pulse: resolved target differs from prediction.
REQ-015 HitCount, MissCount  output  CNTW each  saturating prediction statistics.

Function
REQ-016 State: DEPTH x 32 entry array, TOS pointer (log2 DEPTH bits, wraps), Count (0..DEPTH), PendValid, PendAddr (32).
REQ-017 Per-cycle priority: Flush > Push&Pop > Push > Pop.
REQ-018 Flush: Count<=0, TOS<=0, PendValid<=0; entry array untouched; Push/Pop/ResolveValid ignored that cycle.
REQ-019 Push only: TOS<=TOS+1 mod DEPTH, entry[TOS+1]<=PushAddress, Count<=min(Count+1, DEPTH).
REQ-020 Push at Count==DEPTH: oldest entry overwritten by wrap, Count stays DEPTH; no error flag.
REQ-021 Pop only, Count>0: PendAddr<=entry[TOS], PendValid<=1, TOS<=TOS-1 mod DEPTH, Count<=Count-1.
REQ-022 Pop only, Count==0: TOS/Count unchanged, PendValid<=0, Underflow<=1 next cycle.
REQ-023 Push and Pop same cycle, Count>0: PendAddr<=entry[TOS], PendValid<=1, entry[TOS]<=PushAddress, TOS/Count unchanged.
REQ-024 Push and Pop same cycle, Count==0: behaves as Push only (REQ-019); Underflow<=1, PendValid<=0.
REQ-025 TopAddress = entry[TOS] when Count>0, else 32'h0; reflects writes from the next edge onward (no bypass).
REQ-026 ResolveValid with PendValid=1: if ResolveAddress==PendAddr then HitCount+1 else MissCount+1 and Mispredict<=1; PendValid<=0; same-cycle new Pop re-arms PendValid per REQ-021/023.
REQ-027 ResolveValid with PendValid=0: ignored, no counter change, no Mispredict.
REQ-028 HitCount/MissCount saturate at all-ones; never wrap.
REQ-029 Underflow and Mispredict high exactly one cycle per event, 0 otherwise.

Reset
REQ-030 Reset low, asynchronously: Count=0, TOS=0, PendValid=0, PendAddr=0, Underflow=0, Mispredict=0, HitCount=0, MissCount=0, all entries=0; hence TopAddress=0, TopValid=0.
REQ-031 Reset low mid-operation discards any same-edge Push/Pop/Resolve; first state update on first rising edge after Reset returns high.

Verification
REQ-032 Push 0x100, 0x200, 0x300 on 3 cycles -> TopAddress=0x300, TopValid=1; Pop x3 -> TopAddress 0x200, 0x100, then 0/TopValid=0.
REQ-033 Push 9 addresses 0x4,0x8..0x24 (DEPTH=8) then Pop x8 -> pops return 0x24 down to 0x8; 9th Pop -> Underflow pulse 1 cycle, TopValid=0.
REQ-034 Stack top 0x400, Push 0x500 and Pop same cycle -> next cycle TopAddress=0x500, count unchanged; ResolveValid with 0x400 -> HitCount=1, Mispredict=0.
REQ-035 Push 0x40, Pop, then ResolveValid with 0x44 -> Mispredict=1 one cycle later for one cycle, MissCount=1, HitCount=0.
REQ-036 Push 0x10, 0x20, Pop, then Flush with ResolveValid=1 -> TopValid=0, no counter change; later Push 0x30 -> TopAddress=0x30.
REQ-037 CNTW=2: four hits -> HitCount=3 after third and fourth; Reset low mid-sequence -> all outputs 0 immediately without clock edge.
